// File: rtl/multi_blaster.sv
// Multi-channel launch controller: charge, arm, then salvo or ripple firing of igniter channels.
// Optional over-current exit enabled by defining MULTI_BLASTER_OCP_EN.
module multi_blaster #(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned ADC_W        = 12,
  parameter int unsigned ADC_CYCLES   = 16,
  parameter int unsigned DEBOUNCE     = 64,
  parameter int unsigned FIRE_TIMEOUT = 2400000,
  parameter int unsigned GAP_CYCLES   = 480000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                arm_button,
  input  logic                fire_button,
  input  logic [CHANNELS-1:0] chan_en,
  input  logic                ripple,
  input  logic                lt3420_done,
  output logic                lt3420_charge,
  output logic [CHANNELS-1:0] fire_en,
  output logic                dump,
  output logic                arm_led,
  output logic                ad_req,
  input  logic                adc_valid,
  input  logic [ADC_W-1:0]    vout,
  input  logic [ADC_W-1:0]    iout,
  input  logic [ADC_W-1:0]    vcap,
  input  logic [ADC_W-1:0]    icap,
  input  logic [ADC_W-1:0]    burnout_v,
  input  logic [ADC_W-1:0]    burnout_i,
  input  logic [ADC_W-1:0]    vcap_min,
  input  logic [ADC_W-1:0]    icap_max,
  output logic [CHANNELS-1:0] done_mask,
  output logic [2:0]          state
);

  localparam int unsigned DebW = $clog2(DEBOUNCE + 1);
  localparam int unsigned IntW = $clog2(FIRE_TIMEOUT + 1);
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned SmpW = $clog2(ADC_CYCLES + 1);

  localparam logic [DebW-1:0] DebLoad = DebW'(DEBOUNCE);
  localparam logic [IntW-1:0] IntLoad = IntW'(FIRE_TIMEOUT - 1);
  localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES - 1);
  localparam logic [SmpW-1:0] SmpLoad = SmpW'(ADC_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StCharge    = 3'd1,
    StReady     = 3'd2,
    StFire      = 3'd3,
    StGap       = 3'd4,
    StDischarge = 3'd5,
    StOcp       = 3'd6
  } state_e;

  state_e              r_state, w_state_nxt;
  logic [CHANNELS-1:0] r_pend, w_pend_nxt;
  logic [CHANNELS-1:0] r_done, w_done_nxt;
  logic                r_ripple, w_ripple_nxt;
  logic [DebW-1:0]     r_deb, w_deb_nxt;
  logic [IntW-1:0]     r_int, w_int_nxt;
  logic [GapW-1:0]     r_gap, w_gap_nxt;
  logic [SmpW-1:0]     r_smp, w_smp_nxt;
  logic [23:0]         r_blink;

  logic [CHANNELS-1:0] w_active;
  logic [CHANNELS-1:0] w_pend_left;
  logic                w_burn;
  logic                w_ocp;
  logic                w_uv;
  logic                w_release;

  // Ripple fires only the lowest pending channel; ripple mode is latched at fire press.
  assign w_active    = r_ripple ? (r_pend & (~r_pend + CHANNELS'(1))) : r_pend;
  assign w_pend_left = r_pend & ~w_active;
  assign w_burn      = adc_valid && (vout >= burnout_v) && (iout <= burnout_i);
  assign w_uv        = adc_valid && (vcap < vcap_min);
  assign w_release   = (r_deb == '0) && !fire_button;

`ifdef MULTI_BLASTER_OCP_EN
  assign w_ocp = adc_valid && (icap >= icap_max);
`else
  logic w_unused_icap;
  assign w_unused_icap = ^{icap, icap_max};
  assign w_ocp         = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_pend_nxt   = r_pend;
    w_done_nxt   = r_done;
    w_ripple_nxt = r_ripple;
    w_deb_nxt    = r_deb;
    w_int_nxt    = r_int;
    w_gap_nxt    = r_gap;
    w_smp_nxt    = r_smp;

    if ((r_state == StFire || r_state == StGap) && r_deb != '0) begin
      w_deb_nxt = r_deb - DebW'(1);
    end

    case (r_state)
      StIdle: begin
        if (arm_button) begin
          w_state_nxt = StCharge;
          w_done_nxt  = '0;
        end
      end
      StCharge: begin
        if (!arm_button)      w_state_nxt = StIdle;
        else if (lt3420_done) w_state_nxt = StReady;
      end
      StReady: begin
        if (!arm_button) begin
          w_state_nxt = StIdle;
        end else if (fire_button && chan_en != '0) begin
          w_state_nxt  = StFire;
          w_pend_nxt   = chan_en;
          w_ripple_nxt = ripple;
          w_deb_nxt    = DebLoad;
          w_int_nxt    = IntLoad;
          w_smp_nxt    = SmpLoad;
        end
      end
      StFire: begin
        w_smp_nxt = (r_smp == '0) ? SmpLoad : r_smp - SmpW'(1);
        if (r_int != '0) w_int_nxt = r_int - IntW'(1);
        if (!arm_button || w_release) begin
          w_state_nxt = StDischarge;
        end else if (w_ocp) begin
          w_state_nxt = StOcp;
        end else if (w_uv) begin
          w_state_nxt = StDischarge;
        end else if (w_burn || r_int == '0) begin
          if (w_burn) w_done_nxt = r_done | w_active;
          w_pend_nxt = w_pend_left;
          if (!r_ripple || w_pend_left == '0) begin
            w_state_nxt = StDischarge;
          end else begin
            w_state_nxt = StGap;
            w_gap_nxt   = GapLoad;
          end
        end
      end
      StGap: begin
        if (!arm_button || w_release) begin
          w_state_nxt = StDischarge;
        end else if (r_gap == '0) begin
          w_state_nxt = StFire;
          w_int_nxt   = IntLoad;
          w_smp_nxt   = SmpLoad;
        end else begin
          w_gap_nxt = r_gap - GapW'(1);
        end
      end
`ifdef MULTI_BLASTER_OCP_EN
      StOcp: begin
        if (!arm_button) w_state_nxt = StIdle;
      end
`endif
      StDischarge: begin
        if (!arm_button) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_pend   <= '0;
      r_done   <= '0;
      r_ripple <= 1'b0;
      r_deb    <= DebLoad;
      r_int    <= IntLoad;
      r_gap    <= GapLoad;
      r_smp    <= SmpLoad;
      r_blink  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pend   <= w_pend_nxt;
      r_done   <= w_done_nxt;
      r_ripple <= w_ripple_nxt;
      r_deb    <= w_deb_nxt;
      r_int    <= w_int_nxt;
      r_gap    <= w_gap_nxt;
      r_smp    <= w_smp_nxt;
      r_blink  <= r_blink + 24'd1;
    end
  end

  always_comb begin
    fire_en       = (r_state == StFire) ? w_active : '0;
    lt3420_charge = (r_state == StCharge) || (r_state == StReady);
    dump          = (r_state == StDischarge) || (r_state == StOcp);
    ad_req        = (r_state == StFire) && (r_smp == '0);
    arm_led       = 1'b0;
    if (r_state == StReady || r_state == StFire || r_state == StGap) arm_led = 1'b1;
    else if (r_state == StCharge)                                    arm_led = r_blink[23];
  end

  assign done_mask = r_done;
  assign state     = r_state;

endmodule
